// File: rtl/mac_pkg.sv
// mac_pkg: shared framer states and Ethernet framing constants
package mac_pkg;
    typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;
    localparam logic [7:0]  ETH_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  ETH_SFD_BYTE      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY      = 32'h04C11DB7;
    localparam logic [31:0] ETH_CRC_INIT      = 32'hFFFFFFFF;
endpackage

// File: rtl/mac_lfsr.sv
// mac_lfsr: Galois LFSR/CRC engine; state_out already folds in the pending input word
module mac_lfsr #(
    parameter int                    LFSR_WIDTH = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT  = '1,
    parameter bit                    REVERSE    = 1'b1,
    parameter int                    DATA_WIDTH = 8
) (
    input  logic                  logic_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic [LFSR_WIDTH-1:0] state_out
);
    function automatic logic [LFSR_WIDTH-1:0] reverse_bits(input logic [LFSR_WIDTH-1:0] v);
        logic [LFSR_WIDTH-1:0] r;
        for (int i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
        return r;
    endfunction

    localparam logic [LFSR_WIDTH-1:0] POLY_REV = reverse_bits(LFSR_POLY);

    function automatic logic [LFSR_WIDTH-1:0] step(input logic [LFSR_WIDTH-1:0] s, input logic [DATA_WIDTH-1:0] d);
        logic [LFSR_WIDTH-1:0] r;
        logic                  fb;
        r = s;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE) begin
                fb = r[0] ^ d[i];
                r  = (r >> 1) ^ (fb ? POLY_REV : '0);
            end else begin
                fb = r[LFSR_WIDTH-1] ^ d[DATA_WIDTH-1-i];
                r  = (r << 1) ^ (fb ? LFSR_POLY : '0);
            end
        end
        return r;
    endfunction

    logic [LFSR_WIDTH-1:0] lfsr_q;

    assign state_out = data_valid ? step(lfsr_q, data_in) : lfsr_q;

    always_ff @(posedge logic_clk) begin
        if (rst) lfsr_q <= LFSR_INIT;
        else     lfsr_q <= state_out;
    end
endmodule

// File: rtl/mac_tx_frame_builder.sv
// mac_tx_frame_builder: wraps a raw frame with preamble/SFD, pad, FCS and inter-frame gap
module mac_tx_frame_builder
    import mac_pkg::*;
#(
    parameter int PREAMBLE_LEN  = 7,
    parameter int MIN_FRAME_LEN = 60,
    parameter int IFG_BYTES     = 12,
    parameter int STAT_WIDTH    = 32
) (
    input  logic                  logic_clk,
    input  logic                  logic_rst,
    input  logic [7:0]            s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  s_tuser,
    output logic [7:0]            m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic                  m_tuser,
    input  logic                  cfg_fcs_en,
    output logic                  busy,
    output logic [STAT_WIDTH-1:0] stat_frames,
    output logic [STAT_WIDTH-1:0] stat_errors
);
    state_t      state, state_nxt;
    logic        fcs_en_q, err, err_nxt;
    logic [15:0] byte_cnt;
    logic [16:0] cnt_inc;
    logic [3:0]  pre_cnt;
    logic [1:0]  fcs_idx;
    logic [7:0]  ifg_cnt;
    logic [7:0]  crc_data;
    logic        crc_valid, crc_upd;
    logic [31:0] crc;
    logic        out_ok, s_hs, pad_short, pre_last, ifg_done;
    logic [7:0]  nxt_tdata;
    logic        nxt_tvalid, nxt_tlast, nxt_tuser;

    assign out_ok    = !m_tvalid || m_tready;
    assign s_tready  = (state == DATA) && out_ok;
    assign s_hs      = s_tvalid && s_tready;
    assign busy      = state != IDLE;
    assign cnt_inc   = {1'b0, byte_cnt} + 17'd1;
    assign pad_short = cnt_inc < 17'(MIN_FRAME_LEN);
    assign pre_last  = pre_cnt == 4'(PREAMBLE_LEN - 1);
    assign err_nxt   = err || (s_hs && s_tuser);
    assign crc_upd   = out_ok && ((state == DATA && s_tvalid) || state == PAD);
    // The gap only counts down once the last byte has actually left the output register
    assign ifg_done  = m_tvalid ? (m_tready && ifg_cnt == 8'd0) : (ifg_cnt <= 8'd1);

    mac_lfsr #(
        .LFSR_WIDTH(32),
        .LFSR_POLY (ETH_CRC_POLY),
        .LFSR_INIT (ETH_CRC_INIT),
        .REVERSE   (1'b1),
        .DATA_WIDTH(8)
    ) u_crc (
        .logic_clk (logic_clk),
        .rst       (logic_rst || (state == IDLE && s_tvalid)),
        .data_in   (crc_data),
        .data_valid(crc_valid),
        .state_out (crc)
    );

    always_ff @(posedge logic_clk) begin
        if (logic_rst) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = s_tvalid ? PREAMBLE : IDLE;
            PREAMBLE: if (out_ok && pre_last) state_nxt = SFD;
            SFD:      if (out_ok) state_nxt = DATA;
            DATA:     if (s_hs && s_tlast) state_nxt = pad_short ? PAD : fcs_en_q ? FCS : IFG;
            PAD:      if (out_ok && !pad_short) state_nxt = fcs_en_q ? FCS : IFG;
            FCS:      if (out_ok && fcs_idx == 2'd3) state_nxt = IFG;
            IFG:      if (ifg_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        nxt_tvalid = 1'b0;
        nxt_tdata  = 8'h00;
        nxt_tlast  = 1'b0;
        case (state)
            PREAMBLE: begin
                nxt_tvalid = 1'b1;
                nxt_tdata  = ETH_PREAMBLE_BYTE;
            end
            SFD: begin
                nxt_tvalid = 1'b1;
                nxt_tdata  = ETH_SFD_BYTE;
            end
            DATA: begin
                nxt_tvalid = s_tvalid;
                nxt_tdata  = s_tdata;
                nxt_tlast  = s_tvalid && s_tlast && !pad_short && !fcs_en_q;
            end
            PAD: begin
                nxt_tvalid = 1'b1;
                nxt_tlast  = !pad_short && !fcs_en_q;
            end
            FCS: begin
                nxt_tvalid = 1'b1;
                nxt_tdata  = ~crc[{fcs_idx, 3'b000} +: 8];
                nxt_tlast  = fcs_idx == 2'd3;
            end
            default: ;
        endcase
        nxt_tuser = nxt_tlast && err_nxt;
    end

    always_ff @(posedge logic_clk) begin
        if (logic_rst) begin
            m_tvalid    <= 1'b0;
            m_tdata     <= 8'h00;
            m_tlast     <= 1'b0;
            m_tuser     <= 1'b0;
            fcs_en_q    <= 1'b0;
            err         <= 1'b0;
            byte_cnt    <= 16'd0;
            pre_cnt     <= 4'd0;
            fcs_idx     <= 2'd0;
            ifg_cnt     <= 8'd0;
            crc_data    <= 8'h00;
            crc_valid   <= 1'b0;
            stat_frames <= '0;
            stat_errors <= '0;
        end else begin
            if (out_ok) begin
                m_tvalid <= nxt_tvalid;
                m_tdata  <= nxt_tdata;
                m_tlast  <= nxt_tlast;
                m_tuser  <= nxt_tuser;
            end
            crc_valid <= crc_upd;
            crc_data  <= state == DATA ? s_tdata : 8'h00;
            if (state == IDLE) begin
                fcs_en_q <= cfg_fcs_en;
                err      <= 1'b0;
                byte_cnt <= 16'd0;
                pre_cnt  <= 4'd0;
                fcs_idx  <= 2'd0;
            end
            if (state == PREAMBLE && out_ok) pre_cnt <= pre_cnt + 4'd1;
            if (crc_upd) byte_cnt <= &byte_cnt ? byte_cnt : byte_cnt + 16'd1;
            if (s_hs) err <= err_nxt;
            if (state == FCS && out_ok) fcs_idx <= fcs_idx + 2'd1;
            ifg_cnt <= state != IFG ? 8'(IFG_BYTES) : !m_tvalid ? ifg_cnt - 8'd1 : ifg_cnt;
            if (m_tvalid && m_tready && m_tlast) begin
                stat_frames <= stat_frames + STAT_WIDTH'(1);
                if (m_tuser) stat_errors <= stat_errors + STAT_WIDTH'(1);
            end
        end
    end
endmodule

// File: tb/tb_mac_tx_frame_builder.sv
// tb_mac_tx_frame_builder: directed checks of framing, padding, FCS, backpressure, errors and reset
module tb_mac_tx_frame_builder;
    typedef logic [7:0] bq_t[$];

    logic        logic_clk = 1'b0, logic_rst = 1'b1;
    logic [7:0]  s_tdata = 8'h00, m_tdata;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, s_tready;
    logic        m_tvalid, m_tready = 1'b1, m_tlast, m_tuser, cfg_fcs_en = 1'b0, busy;
    logic [31:0] stat_frames, stat_errors;

    logic [7:0]  n_s_tdata = 8'h00, n_m_tdata;
    logic        n_s_tvalid = 1'b0, n_s_tlast = 1'b0, n_s_tready;
    logic        n_m_tvalid, n_m_tlast, n_m_tuser, n_busy;
    logic [31:0] n_stat_frames, n_stat_errors;

    mac_tx_frame_builder dut (
        .logic_clk(logic_clk), .logic_rst(logic_rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .cfg_fcs_en(cfg_fcs_en), .busy(busy), .stat_frames(stat_frames), .stat_errors(stat_errors)
    );

    mac_tx_frame_builder #(.MIN_FRAME_LEN(0)) dut_np (
        .logic_clk(logic_clk), .logic_rst(logic_rst),
        .s_tdata(n_s_tdata), .s_tvalid(n_s_tvalid), .s_tready(n_s_tready), .s_tlast(n_s_tlast), .s_tuser(1'b0),
        .m_tdata(n_m_tdata), .m_tvalid(n_m_tvalid), .m_tready(1'b1), .m_tlast(n_m_tlast), .m_tuser(n_m_tuser),
        .cfg_fcs_en(1'b1), .busy(n_busy), .stat_frames(n_stat_frames), .stat_errors(n_stat_errors)
    );

    always #5 logic_clk = ~logic_clk;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    bq_t  cap_d, nq;
    logic cap_l[$], cap_u[$], nl[$];
    int   tl_cnt = 0, n_tl = 0, cyc = 0, hs_cyc = 0, last_gap = 0, idle_cnt = 0;
    int   stalls = 0, stall_viol = 0, tail_rdy = 0;
    bit   gap_pend = 0, counting = 0, in_tail = 0, rnd = 0, prev_stall = 0;
    logic [10:0] prev_out = '0;

    always @(posedge logic_clk) begin
        #1 m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge logic_clk) begin
        cyc++;
        if (prev_stall) begin
            stalls++;
            if ({m_tvalid, m_tdata, m_tlast, m_tuser} !== prev_out) stall_viol++;
        end
        prev_stall = m_tvalid && !m_tready;
        prev_out   = {m_tvalid, m_tdata, m_tlast, m_tuser};
        if (counting) begin
            if (busy && !m_tvalid) idle_cnt++;
            else counting = 0;
        end
        if (gap_pend && m_tvalid) begin
            last_gap = cyc - hs_cyc - 1;
            gap_pend = 0;
        end
        if (in_tail && s_tready) tail_rdy++;
        if (m_tvalid && m_tready) begin
            cap_d.push_back(m_tdata);
            cap_l.push_back(m_tlast);
            cap_u.push_back(m_tuser);
            if (m_tlast) begin
                tl_cnt++;
                hs_cyc   = cyc;
                gap_pend = 1;
                counting = 1;
                idle_cnt = 0;
                in_tail  = 0;
            end
        end
        if (n_m_tvalid) begin
            nq.push_back(n_m_tdata);
            nl.push_back(n_m_tlast);
            if (n_m_tlast) n_tl++;
        end
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        for (int b = 0; b < 8; b++) c = (c[0] ^ d[b]) ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        return c;
    endfunction

    function automatic bq_t build(input bq_t pl, input bit fcs);
        bq_t         q;
        bq_t         body;
        logic [31:0] c;
        body = pl;
        c    = 32'hFFFFFFFF;
        while (body.size() < 60) body.push_back(8'h00);
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        foreach (body[i]) begin
            q.push_back(body[i]);
            c = crc_byte(c, body[i]);
        end
        c = ~c;
        if (fcs) for (int k = 0; k < 4; k++) q.push_back(c[8*k +: 8]);
        return q;
    endfunction

    task automatic clear_caps();
        cap_d.delete();
        cap_l.delete();
        cap_u.delete();
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_m_tvalid"}, 32'(m_tvalid), 0);
        check({tag, "_m_tdata"}, 32'(m_tdata), 0);
        check({tag, "_m_tlast"}, 32'(m_tlast), 0);
        check({tag, "_m_tuser"}, 32'(m_tuser), 0);
        check({tag, "_s_tready"}, 32'(s_tready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_frames"}, stat_frames, 0);
        check({tag, "_errors"}, stat_errors, 0);
    endtask

    task automatic send(input bq_t pl, input int err_at, input int rst_at);
        int i = 0, t = 0;
        bit hs;
        @(posedge logic_clk);
        #1;
        while (i < pl.size() && t < 4000) begin
            if (i == rst_at) begin
                logic_rst = 1'b1;
                @(posedge logic_clk);
                #1 logic_rst = 1'b0;
                break;
            end
            s_tvalid = 1'b1;
            s_tdata  = pl[i];
            s_tlast  = i == pl.size() - 1;
            s_tuser  = i == err_at;
            @(negedge logic_clk);
            hs = s_tready;
            @(posedge logic_clk);
            #1;
            if (hs) i++;
            t++;
        end
        check("send_timeout", 32'(t < 4000), 1);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tuser  = 1'b0;
        in_tail  = i == pl.size();
    endtask

    task automatic send_np(input bq_t pl);
        int i = 0, t = 0;
        bit hs;
        @(posedge logic_clk);
        #1;
        while (i < pl.size() && t < 2000) begin
            n_s_tvalid = 1'b1;
            n_s_tdata  = pl[i];
            n_s_tlast  = i == pl.size() - 1;
            @(negedge logic_clk);
            hs = n_s_tready;
            @(posedge logic_clk);
            #1;
            if (hs) i++;
            t++;
        end
        check("np_send_timeout", 32'(t < 2000), 1);
        n_s_tvalid = 1'b0;
        n_s_tlast  = 1'b0;
    endtask

    task automatic wait_tl(input int n);
        int t = 0;
        while (tl_cnt < n && t < 3000) begin
            @(negedge logic_clk);
            t++;
        end
        check($sformatf("tlast_wait%0d", n), 32'(tl_cnt >= n), 1);
        repeat (20) @(negedge logic_clk);
    endtask

    task automatic cmp(input string tag, input bq_t exp, input int nlast_exp);
        int nlc = 0;
        check({tag, "_len"}, cap_d.size(), exp.size());
        foreach (exp[i])
            check($sformatf("%s_byte%0d", tag, i), i < cap_d.size() ? 32'(cap_d[i]) : 32'hFFFFFFFF, 32'(exp[i]));
        foreach (cap_l[i]) if (cap_l[i]) nlc++;
        check({tag, "_nlast"}, nlc, nlast_exp);
        check({tag, "_lastpos"}, cap_l.size() > 0 ? 32'(cap_l[cap_l.size()-1]) : 32'd0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t pl, pl2, exp, ref_q;
        int  nu, nlc;
        repeat (3) @(posedge logic_clk);
        #1 logic_rst = 1'b0;
        @(negedge logic_clk);
        chk_reset("reset");

        // CRC check value of "123456789" with padding disabled
        for (int k = 1; k <= 9; k++) pl.push_back(8'(8'h30 + k));
        send_np(pl);
        for (int t = 0; t < 200 && n_tl < 1; t++) @(negedge logic_clk);
        exp = {};
        repeat (7) exp.push_back(8'h55);
        exp.push_back(8'hD5);
        foreach (pl[i]) exp.push_back(pl[i]);
        exp.push_back(8'h26);
        exp.push_back(8'h39);
        exp.push_back(8'hF4);
        exp.push_back(8'hCB);
        check("np_len", nq.size(), exp.size());
        foreach (exp[i]) check($sformatf("np_byte%0d", i), i < nq.size() ? 32'(nq[i]) : 32'hFFFFFFFF, 32'(exp[i]));
        check("np_lastpos", nl.size() > 0 ? 32'(nl[nl.size()-1]) : 32'd0, 1);
        check("np_frames", n_stat_frames, 1);

        // FCS off, full-length payload, no stall
        cfg_fcs_en = 1'b0;
        clear_caps();
        pl = {};
        for (int k = 0; k < 60; k++) pl.push_back(8'(k));
        send(pl, -1, -1);
        wait_tl(1);
        cmp("nofcs", build(pl, 0), 1);
        check("nofcs_idle", idle_cnt, 12);
        check("nofcs_user", cap_u.size() > 0 ? 32'(cap_u[cap_u.size()-1]) : 32'd1, 0);
        check("nofcs_frames", stat_frames, 1);

        // one-byte payload padded, FCS on
        cfg_fcs_en = 1'b1;
        clear_caps();
        tail_rdy = 0;
        pl = {8'hAB};
        send(pl, -1, -1);
        wait_tl(2);
        exp = build(pl, 1);
        cmp("pad", exp, 1);
        check("pad_tready_tail", tail_rdy, 0);
        ref_q = cap_d;

        // same frame under random backpressure
        clear_caps();
        stalls = 0;
        stall_viol = 0;
        rnd = 1;
        send(pl, -1, -1);
        wait_tl(3);
        rnd = 0;
        cmp("stall", ref_q, 1);
        check("stall_stable", stall_viol, 0);
        check("stall_seen", 32'(stalls > 0), 1);

        // errored frame followed back-to-back by a clean one
        clear_caps();
        pl = {};
        pl2 = {};
        for (int k = 0; k < 20; k++) begin
            pl.push_back(8'(8'h10 + k));
            pl2.push_back(8'(8'h80 + k));
        end
        send(pl, 10, -1);
        send(pl2, -1, -1);
        wait_tl(5);
        exp = build(pl, 1);
        ref_q = build(pl2, 1);
        nlc = exp.size();
        foreach (ref_q[i]) exp.push_back(ref_q[i]);
        cmp("err", exp, 2);
        nu = 0;
        foreach (cap_u[i]) if (cap_u[i]) nu++;
        check("err_user_count", nu, 1);
        check("err_user_f1", cap_u.size() >= nlc ? 32'(cap_u[nlc-1]) : 32'd0, 1);
        check("err_last_f1", cap_l.size() >= nlc ? 32'(cap_l[nlc-1]) : 32'd0, 1);
        check("err_errors", stat_errors, 1);
        check("err_frames", stat_frames, 5);
        check("err_gap", 32'(last_gap >= 13), 1);

        // reset in the middle of a frame
        clear_caps();
        pl = {};
        for (int k = 0; k < 40; k++) pl.push_back(8'(8'hC0 + k));
        send(pl, -1, 20);
        @(negedge logic_clk);
        chk_reset("rst_mid");
        check("rst_no_tlast", tl_cnt, 5);
        clear_caps();
        pl = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        send(pl, -1, -1);
        wait_tl(6);
        cmp("after_rst", build(pl, 1), 1);
        check("after_rst_frames", stat_frames, 1);
        check("after_rst_errors", stat_errors, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
